// File: rtl/card_shoe_if.sv
// Request/response bundle between the card shoe and the card registers.
// The consumer drives deal_req/reshuffle; the shoe drives everything else.
interface card_shoe_if;
    logic       deal_req;
    logic       reshuffle;
    logic [3:0] card_out;
    logic       card_valid;
    logic [9:0] cards_left;
    logic       shoe_empty;

    modport master (
        output deal_req, reshuffle,
        input  card_out, card_valid, cards_left, shoe_empty
    );

    modport slave (
        input  deal_req, reshuffle,
        output card_out, card_valid, cards_left, shoe_empty
    );
endinterface

// File: rtl/card_shoe.sv
// Finite card shoe: deals ranks 1..13 without replacement from DECKS decks,
// one card per level request, with per-rank counts, reshuffle and empty flag.
module card_shoe #(
    parameter int DECKS = 1
) (
    input  logic        fast_clock,
    input  logic        resetb,
    card_shoe_if.slave  bus
);
    localparam logic [5:0] RANK_FULL = 6'(4 * DECKS);
    localparam logic [9:0] SHOE_FULL = 10'(52 * DECKS);

    typedef enum logic [1:0] {IDLE, SEARCH, HOLD} state_t;

    state_t     state, state_d;
    logic [3:0] rank_ctr;
    logic [3:0] probe, probe_d;
    logic [3:0] card_out, card_out_d;
    logic       card_valid, valid_d;
    logic       take;
    logic       hit;
    logic [5:0] counts [1:13];
    logic [9:0] cards_left;

    assign hit = (counts[probe] != 6'd0);

    // NOTE: every output of this block gets a default first, so no path infers a latch.
    always_comb begin
        state_d    = state;
        probe_d    = probe;
        card_out_d = card_out;
        valid_d    = 1'b0;
        take       = 1'b0;
        if (bus.reshuffle) begin
            state_d = bus.deal_req ? HOLD : IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.deal_req && cards_left != 10'd0) begin
                        probe_d = rank_ctr;
                        state_d = SEARCH;
                    end
                end
                SEARCH: begin
                    if (hit) begin
                        take       = 1'b1;
                        valid_d    = 1'b1;
                        card_out_d = probe;
                        state_d    = HOLD;
                    end else begin
                        probe_d = (probe == 4'd13) ? 4'd1 : probe + 4'd1;
                    end
                end
                HOLD: begin
                    if (!bus.deal_req) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge fast_clock or negedge resetb) begin
        if (!resetb) begin
            state      <= IDLE;
            probe      <= 4'd1;
            card_out   <= 4'd0;
            card_valid <= 1'b0;
        end else begin
            state      <= state_d;
            probe      <= probe_d;
            card_out   <= card_out_d;
            card_valid <= valid_d;
        end
    end

    // NOTE: the count array is reset, not left uninitialised, because the shoe must be full out of reset.
    always_ff @(posedge fast_clock or negedge resetb) begin
        if (!resetb) begin
            rank_ctr   <= 4'd1;
            counts     <= '{default: RANK_FULL};
            cards_left <= SHOE_FULL;
        end else begin
            rank_ctr <= (rank_ctr == 4'd13) ? 4'd1 : rank_ctr + 4'd1;
            if (bus.reshuffle) begin
                counts     <= '{default: RANK_FULL};
                cards_left <= SHOE_FULL;
            end else if (take) begin
                counts[probe] <= counts[probe] - 6'd1;
                cards_left    <= cards_left - 10'd1;
            end
        end
    end

    assign bus.card_out   = card_out;
    assign bus.card_valid = card_valid;
    assign bus.cards_left = cards_left;
    assign bus.shoe_empty = (cards_left == 10'd0);
endmodule

// File: doc/card_shoe.md
# card_shoe

Finite card shoe for the baccarat datapath. It deals ranks 1–13 without replacement from `DECKS` standard decks, one card per request. It sits directly upstream of the card registers, which load `card_out` on their own load strobes. It replaces a with-replacement card counter with a tracked shoe: per-rank counts, a reshuffle command and an empty flag.

## Interface
- `DECKS`, default 1: number of 52-card decks in the shoe. Legal range is 1..8.
- `fast_clock` input 1: the single clock. Every register updates on its rising edge.
- `resetb` input 1: asynchronous, active-low reset.
- `deal_req` input 1: level request for one card. It must be synchronous to `fast_clock`.
- `reshuffle` input 1: refills the shoe to full.
- `card_out` output 4: last dealt rank, 1..13. It holds until the next deal.
- `card_valid` output 1: one-cycle pulse. `card_out` is new while it is high.
- `cards_left` output 10: number of cards remaining in the shoe.
- `shoe_empty` output 1: high while `cards_left`==0.

## Operation
- **Storage:** 13 rank counters, 6 bits each, one per rank. Full value of each is 4·`DECKS`. Full `cards_left` is 52·`DECKS`.
- **rank_ctr:** free-running, 4 bits. It is 1 after reset and advances every edge: 1,2,…,13,1,…
- **States:** IDLE, SEARCH, HOLD.
- **IDLE:**
  - `deal_req`=1 and `cards_left`>0: `probe`<=`rank_ctr`, go to SEARCH.
  - `deal_req`=1 and `cards_left`=0: stay in IDLE. No card is dealt and `card_valid` stays low.
- **SEARCH, hit** (count[`probe`]≠0):
  - count[`probe`] decrements and `cards_left` decrements.
  - `card_out`<=`probe`, `card_valid`<=1, go to HOLD.
- **SEARCH, miss** (count[`probe`]=0):
  - `probe`<=`probe`+1, wrapping 13→1. Stay in SEARCH.
  - A hit is guaranteed within 13 probes, because `cards_left`>0 on entry.
- **HOLD:**
  - `card_valid`<=0 on the first edge in HOLD.
  - Stay in HOLD while `deal_req`=1. Go to IDLE when `deal_req`=0.
  - Holding `deal_req` high therefore yields exactly one card.
- **reshuffle=1, any state:**
  - Overrides everything else.
  - All counts go to full and `cards_left` goes to 52·`DECKS`. `card_valid`<=0.
  - A pending SEARCH is aborted with no card and no decrement.
  - Next state is HOLD if `deal_req`=1, otherwise IDLE.
  - `card_out` is unchanged.
- **shoe_empty:** decoded from the `cards_left` register. It goes high in the same cycle that `cards_left` becomes 0.
- **Arithmetic:** counters never decrement below 0 and never exceed full. `probe` and `card_out` never take the values 0, 14 or 15.

## Timing
- **Reset values** (asynchronous, on `resetb`=0):
  - state IDLE, `rank_ctr`=1, all counts full.
  - `cards_left`=52·`DECKS`, `card_out`=0, `card_valid`=0, `shoe_empty`=0.
- **Reset mid-operation:** any in-flight request is abandoned immediately. The shoe is full again on release.
- **Accept:** call the accepting edge E0. `probe` equals the `rank_ctr` value present before E0.
- **Latency:**
  - With m misses, `card_valid` goes high after edge E(1+m) and is low again after E(2+m).
  - Minimum latency is 1 edge after accept and maximum is 13.
- **Updates:** `card_out`, `cards_left` and `card_valid` all change on the same edge.
- **Re-request:** the earliest next accept is the edge after `deal_req` is first seen low in HOLD, plus one more cycle for IDLE.
- **Simultaneous reshuffle and hit:** reshuffle wins, so there is no `card_valid` and no decrement.

## Test plan
- **First card after reset:**
  - Stimulus: `DECKS`=1; release reset; `deal_req`=1 before the first edge.
  - Required: `card_out`=1 and `card_valid` high for exactly 1 cycle, after the 2nd edge. `cards_left`=51.
- **Level handshake:**
  - Stimulus: `deal_req` held high for 20 cycles.
  - Required: exactly one `card_valid` pulse.
  - Then: drop `deal_req` for 1 cycle and raise it again; a second pulse follows and `cards_left`=50.
- **Depleted rank probing:**
  - Stimulus: deal four 7s by timing accepts while `rank_ctr`=7; then issue a fifth accept while `rank_ctr`=7.
  - Required: the fifth deal gives `card_out`=8 with latency 2 edges; count[7]=0.
- **Exhaust the shoe:**
  - Stimulus: 52 deals.
  - Required:
    - 52 `card_valid` pulses and a histogram of exactly 4 per rank.
    - `shoe_empty`=1 and `cards_left`=0 after the 52nd pulse.
    - A 53rd request gives no `card_valid` for 30 cycles.
  - Then: reshuffle; `cards_left`=52 and `shoe_empty`=0.
- **Reshuffle during SEARCH:**
  - Stimulus: empty ranks 1–12; accept with `rank_ctr`=1; pulse `reshuffle` on the 3rd SEARCH cycle while `deal_req`=1.
  - Required: no `card_valid`, `cards_left`=52, state HOLD until `deal_req` drops.
- **Async reset in HOLD:**
  - Stimulus: pull `resetb` low between clock edges.
  - Required: all outputs take their reset values immediately, without waiting for an edge. `cards_left`=52.
